// File: rtl/vga_sync_decoder_if.sv
// Sync input and decoded-position bundle for the VGA sync decoder.
// VGA_SYNC_ERR_CNT_EN adds the lock_loss_cnt status field.
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        video_on;
  logic        locked;
  logic        frame_start;
  logic [15:0] line_len;
  logic [15:0] frame_lines;
`ifdef VGA_SYNC_ERR_CNT_EN
  logic [15:0] lock_loss_cnt;

  modport master (
    output hsync, vsync,
    input  pixel_x, pixel_y, video_on, locked,
    input  frame_start, line_len, frame_lines,
    input  lock_loss_cnt
  );

  modport slave (
    input  hsync, vsync,
    output pixel_x, pixel_y, video_on, locked,
    output frame_start, line_len, frame_lines,
    output lock_loss_cnt
  );
`else
  modport master (
    output hsync, vsync,
    input  pixel_x, pixel_y, video_on, locked,
    input  frame_start, line_len, frame_lines
  );

  modport slave (
    input  hsync, vsync,
    output pixel_x, pixel_y, video_on, locked,
    output frame_start, line_len, frame_lines
  );
`endif
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds VGA position counters from hsync/vsync and locks to 640x480@60.
// Define VGA_SYNC_ERR_CNT_EN to add the saturating lock_loss_cnt output.
module vga_sync_decoder #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480
) (
  input logic clk_25MHz,
  input logic reset,
  vga_sync_decoder_if.slave bus
);

  localparam logic [15:0] HT    = 16'(H_TOTAL);
  localparam logic [15:0] VT    = 16'(V_TOTAL);
  localparam logic [15:0] H_ST  = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_END = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ST  = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_END = 16'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [15:0] H_TMO = 16'(2 * H_TOTAL);
  localparam logic [15:0] V_TMO = 16'(V_TOTAL + V_SYNC);
  localparam logic [15:0] SAT   = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t      state_q;
  logic        frame_start_q;
  logic        hs_r_q, vs_r_q;
  logic        vs_pend_q, vs_pend_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [15:0] line_len_q, line_len_d;
  logic [15:0] frame_lines_q, frame_lines_d;

  logic        hs_fall, vs_fall, boundary;
  logic [15:0] h_inc, v_inc;
  logic        h_len_ok, v_len_ok;
  logic        timeout, lock_drop;
  logic        hwin, vwin;

  assign hs_fall  = hs_r_q & ~bus.hsync;
  assign vs_fall  = vs_r_q & ~bus.vsync;
  assign boundary = hs_fall & (vs_fall | vs_pend_q);
  assign h_inc    = h_cnt_q + 16'd1;
  assign v_inc    = v_cnt_q + 16'd1;
  assign h_len_ok = (h_inc == HT);
  assign v_len_ok = (v_inc == VT);
  assign timeout  = (h_cnt_q >= H_TMO) | (v_cnt_q >= V_TMO);

  // A locked state is lost on a timeout, bad line, or bad frame height.
  assign lock_drop = (state_q == LOCKED) &
                     (timeout |
                      (hs_fall & (~h_len_ok |
                                  (boundary & ~v_len_ok))));

  // Next-state for counters and measurements; vs_fall arms a frame boundary.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    vs_pend_d     = vs_pend_q | vs_fall;
    if (hs_fall) begin
      line_len_d = h_inc;
      h_cnt_d    = '0;
    end else if (h_cnt_q != SAT) begin
      h_cnt_d = h_inc;
    end
    if (boundary) begin
      frame_lines_d = v_inc;
      v_cnt_d       = '0;
      vs_pend_d     = 1'b0;
    end else if (hs_fall && v_cnt_q != SAT) begin
      v_cnt_d = v_inc;
    end
  end

  // Sync edge registers, position counters and measurements.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      hs_r_q        <= 1'b1;
      vs_r_q        <= 1'b1;
      vs_pend_q     <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      hs_r_q        <= bus.hsync;
      vs_r_q        <= bus.vsync;
      vs_pend_q     <= vs_pend_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  // Lock FSM, stepped on each hsync fall, with timeouts overriding.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      if (timeout) begin
        state_q <= SEARCH;
      end else if (hs_fall) begin
        unique case (state_q)
          SEARCH: begin
            if (boundary) state_q <= VERIFY;
          end
          VERIFY: begin
            if (!h_len_ok) begin
              state_q <= SEARCH;
            end else if (boundary && v_len_ok) begin
              state_q       <= LOCKED;
              frame_start_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (boundary) frame_start_q <= 1'b1;
            if (lock_drop) state_q <= SEARCH;
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

`ifdef VGA_SYNC_ERR_CNT_EN
  logic [15:0] loss_q;

  // Counts lock losses, holding at full scale.
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      loss_q <= '0;
    end else if (lock_drop && loss_q != SAT) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign bus.lock_loss_cnt = loss_q;
`endif

  assign hwin = (h_cnt_q >= H_ST) && (h_cnt_q < H_END);
  assign vwin = (v_cnt_q >= V_ST) && (v_cnt_q < V_END);

  assign bus.locked      = (state_q == LOCKED);
  assign bus.video_on    = bus.locked & hwin & vwin;
  assign bus.pixel_x     = hwin ? (h_cnt_q - H_ST) : '0;
  assign bus.pixel_y     = vwin ? (v_cnt_q - V_ST) : '0;
  assign bus.frame_start = frame_start_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. Samples incoming hsync/vsync on the pixel clock, rebuilds the horizontal and vertical position counters, and measures line length and frame height. Declares lock once one full frame matches the nominal 640x480@60 timing. Sits on the capture/loopback path and supplies pixel_x/pixel_y/video_on to downstream consumers and line_len/frame_lines to the status registers.

Parameters:
H_TOTAL, 800, clocks per line
H_SYNC, 96, hsync low width in clocks
H_BP, 48, back porch in clocks; H_START = H_SYNC + H_BP = 144
H_ACTIVE, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync low width in lines
V_BP, 33, back porch in lines; V_START = V_SYNC + V_BP = 35
V_ACTIVE, 480, visible lines per frame

Ports:
clk_25MHz  input  1  pixel clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
hsync  input  1  active-low horizontal sync, synchronous to clk_25MHz
vsync  input  1  active-low vertical sync, synchronous to clk_25MHz
pixel_x  output  16  active column 0..639; 0 outside the active window
pixel_y  output  16  active row 0..479; 0 outside the active window
video_on  output  1  high when locked and inside the active window
locked  output  1  high in LOCKED state
frame_start  output  1  one-cycle pulse at each frame boundary while locked
line_len  output  16  last measured line length in clocks
frame_lines  output  16  last measured frame height in lines

Behaviour:
- Reset values: h_cnt=0, v_cnt=0, hs_r=1, vs_r=1, vs_pend=0, state=SEARCH, line_len=0, frame_lines=0, frame_start=0. Outputs derived from these read 0.
- hs_r and vs_r register hsync and vsync. hs_fall = hs_r & ~hsync. vs_fall = vs_r & ~vsync.
- h_cnt: on hs_fall, line_len <= h_cnt+1 and h_cnt <= 0. Otherwise h_cnt increments, saturating at 0xFFFF. For an 800-clock line, h_cnt runs 0..799 and line_len=800.
- vs_fall sets vs_pend. On hs_fall, if (vs_fall | vs_pend): frame_lines <= v_cnt+1, v_cnt <= 0, vs_pend <= 0 (this is a "frame boundary"). Otherwise v_cnt increments, saturating at 0xFFFF. A vs_fall in the same cycle as hs_fall takes effect immediately.
- FSM, evaluated on hs_fall:
  - SEARCH -> VERIFY at a frame boundary.
  - VERIFY -> SEARCH if h_cnt+1 != H_TOTAL.
  - VERIFY -> LOCKED at the next frame boundary if v_cnt+1 == V_TOTAL; otherwise VERIFY -> VERIFY and the check restarts.
  - LOCKED -> SEARCH on line length != H_TOTAL, or on a frame boundary with v_cnt+1 != V_TOTAL.
- Timeouts, checked every cycle: h_cnt reaching 2*H_TOTAL (missing hsync), or v_cnt reaching V_TOTAL+V_SYNC (missing vsync), forces SEARCH from any state on the next edge.
- frame_start: registered pulse, high for the single cycle after a frame boundary that occurs in LOCKED or completes VERIFY->LOCKED.
- Combinational outputs, decoded from the registered h_cnt, v_cnt and state:
  - hwin = (h_cnt >= H_START) && (h_cnt < H_START+H_ACTIVE); vwin is the same test on v_cnt with V_START and V_ACTIVE.
  - video_on = locked & hwin & vwin.
  - pixel_x = hwin ? h_cnt-H_START : 0. pixel_y = vwin ? v_cnt-V_START : 0.
  - All arithmetic is 16-bit unsigned.
- Reset mid-frame returns to SEARCH. Lock requires a full boundary-to-boundary frame after the next vsync.

Optional Feature:
- Macro: VGA_SYNC_ERR_CNT_EN.
- Defined: adds output port lock_loss_cnt (16 bits). It increments, saturating at 0xFFFF, on every LOCKED->SEARCH transition, and resets to 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Nominal 800x525 stream from the timing generator -> locked rises at the end of the 2nd frame boundary after the first vsync; frame_lines=525; line_len=800; one frame_start per frame.
- Locked: h_cnt=144 on row v_cnt=35 -> video_on=1, pixel_x=0, pixel_y=0. h_cnt=783, v_cnt=514 -> pixel_x=639, pixel_y=479. h_cnt=784 -> video_on=0, pixel_x=0.
- Locked: one line shortened to 799 clocks -> line_len=799, locked falls on that hsync edge, relock after 2 good boundaries.
- hsync held high while locked -> locked falls when h_cnt reaches 1600; h_cnt saturates, no wrap.
- vsync falling mid-line (h_cnt=400) -> v_cnt resets on the following hsync fall, not earlier; a simultaneous hs/vs fall resets in the same cycle.
- Reset asserted mid-frame while locked -> all outputs 0 immediately; with VGA_SYNC_ERR_CNT_EN, lock_loss_cnt=0 after reset and increments to 1 on a forced loss.
